// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between a UART receiver and its consumer.
// Bytes arriving while full with no concurrent pop are dropped and counted.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  clear_ovf
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LvlFull = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LvlOne  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = LvlOne[DEPTH_LOG2-1:0];

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_q, drop_d;
  logic                  push, pop, drop;

  assign full       = (level_q == LvlFull);
  assign out_valid  = (level_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase
    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      ovf_d = 1'b1;
      if (clear_ovf)           drop_d = 8'd1;
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is deliberately not reset; contents are unobservable while empty.
  always_ff @(posedge CLK) begin
    if (push && !RST) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001: Parameter DEPTH_LOG2, default 4, log2 of entry count (DEPTH = 2^DEPTH_LOG2 = 16 bytes).
REQ-002: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003: RST  input  1  reset, asynchronous and active-high.
REQ-004: in_data  input  8  received byte from UART receiver.
REQ-005: in_valid  input  1  one-cycle strobe; byte on in_data is present; no backpressure to source.
REQ-006: out_data  output  8  head-of-queue byte; meaningful only while out_valid=1.
REQ-007: out_valid  output  1  queue non-empty.
REQ-008: out_ready  input  1  consumer (UART transmitter / host logic) accepts head byte.
REQ-009: level  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-010: full  output  1  level == DEPTH.
REQ-011: overflow  output  1  sticky; set when a byte was dropped.
REQ-012: drop_count  output  8  number of dropped bytes since last clear, saturating at 255.
REQ-013: clear_ovf  input  1  one-cycle strobe clearing overflow and drop_count.

Function
REQ-014: Storage SHALL be a DEPTH x 8 array with DEPTH_LOG2-bit read and write pointers that wrap modulo DEPTH.
REQ-015: push = in_valid AND (NOT full OR pop); pop = out_valid AND out_ready.
REQ-016: On push, in_data SHALL be written at wr_ptr and wr_ptr incremented at the same edge.
REQ-017: On pop, rd_ptr SHALL increment at that edge.
REQ-018: level SHALL become level+1 on push only, level-1 on pop only, unchanged on both or neither.
REQ-019: out_valid SHALL equal (level != 0); out_data SHALL equal array[rd_ptr] combinationally (first-word-fall-through).
REQ-020: Latency: byte pushed at edge N SHALL be visible on out_data with out_valid=1 after edge N when queue was empty (one cycle from strobe).
REQ-021: Pop while empty SHALL be impossible (out_valid=0 gates it); out_ready while empty SHALL have no effect.
REQ-022: Full AND in_valid AND pop in the same cycle SHALL accept the byte; level stays DEPTH; no drop.
REQ-023: Full AND in_valid AND no pop SHALL drop the byte: no pointer or level change, overflow<=1, drop_count<=min(drop_count+1, 255).
REQ-024: Byte order at out_data SHALL exactly match accepted in_valid order, including across pointer wrap.
REQ-025: clear_ovf SHALL set overflow<=0 and drop_count<=0; a drop in the same cycle SHALL win (overflow<=1, drop_count<=1).
REQ-026: full SHALL be derived from level, not from pointer compare.
REQ-027: Block SHALL contain no combinational path from in_valid to out_valid.

Reset
REQ-028: While RST=1, rd_ptr, wr_ptr, level SHALL be 0, out_valid=0, full=0, overflow=0, drop_count=0, immediately and independent of CLK.
REQ-029: Array contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-030: RST asserted mid-operation SHALL discard all queued bytes; first push after RST release SHALL appear as the head byte.
REQ-031: in_valid and out_ready asserted while RST=1 SHALL have no effect.

Verification
REQ-032: Single byte: out_ready=0, strobe in_valid with 0x41 -> next cycle out_valid=1, out_data=0x41, level=1; out_ready=1 one cycle -> level=0, out_valid=0.
REQ-033: Fill and wrap: push 0x00..0x0F, pop all, push 0x10..0x17, pop all -> output sequence 0x00..0x17 in order, full=1 only at level 16.
REQ-034: Overflow: out_ready=0, push 20 bytes 0x80..0x93 -> level=16, overflow=1, drop_count=4, queue holds 0x80..0x8F; clear_ovf -> overflow=0, drop_count=0.
REQ-035: Full with simultaneous push+pop: level=16, in_valid=1 with 0xAA and out_ready=1 -> level=16, no drop, 0xAA emerges 16th after.
REQ-036: Saturation: hold full, 300 dropped strobes -> drop_count=255; clear_ovf coincident with a drop -> drop_count=1, overflow=1.
REQ-037: Async reset: 5 bytes queued, pulse RST between clock edges -> level=0, out_valid=0 before next edge; push 0x55 -> out_data=0x55.
